branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Consumer end of the 2-bit branch predictor interface.
- Captures the IF-stage prediction (direction plus target) for each fetched instruction and carries it through the ID and EX pipeline slots.
- At EX, compares the prediction against the actual branch outcome. On a mismatch it drives the pipeline flush and fetch redirect.
- Produces the per-branch update strobe (pc, taken) that trains the predictor's history table, and keeps branch/mispredict performance counters.

Parameters:
- XLEN, 32, width of PC and target fields.
- CNT_W, 32, width of performance counters; counters saturate at all-ones.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_valid_i  in  1  IF slot holds a real instruction this cycle.
- if_pc_i  in  XLEN  PC of the IF instruction.
- if_pred_taken_i  in  1  predictor direction for if_pc_i.
- if_pred_target_i  in  XLEN  target fetch used if predicted taken.
- stall_i  in  1  front-end freeze; ID and EX slots hold.
- flush_i  in  1  external kill (trap/exception); clears ID and EX slots.
- ex_is_branch_i  in  1  EX instruction is a conditional branch (from decode).
- ex_taken_i  in  1  actual branch outcome at EX.
- ex_target_i  in  XLEN  actual branch target at EX.
- flush_o  out  1  mispredict; kill IF and ID contents.
- redirect_pc_o  out  XLEN  correct next fetch PC, valid with flush_o.
- upd_valid_o  out  1  train predictor this cycle.
- upd_pc_o  out  XLEN  PC to index predictor (bits [5:2] used by predictor).
- upd_taken_o  out  1  actual outcome for predictor training.
- br_cnt_o  out  CNT_W  resolved conditional branches.
- mispred_cnt_o  out  CNT_W  mispredicted conditional branches.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: ID and EX valid bits = 0; stored pc/pred/target = 0; counters = 0. All outputs are therefore 0 during and immediately after reset.
- Two slot registers, ID and EX. Each holds {valid, pc, pred_taken, pred_target}.
- Slot advance, in priority order:
  - flush_i or flush_o: next ID.valid = 0 and next EX.valid = 0. The resolving EX entry completes this cycle.
  - else stall_i: both slots hold.
  - else: EX <= ID, ID <= {if_valid_i, if_pc_i, if_pred_taken_i, if_pred_target_i}.
- Resolution happens when res = EX.valid & ex_is_branch_i & ~stall_i & ~flush_i. It is combinational, same cycle as the EX inputs.
- Mispredict when res and any of:
  - pred_taken=1 and ex_taken_i=0 -> redirect_pc_o = EX.pc + 4.
  - pred_taken=0 and ex_taken_i=1 -> redirect_pc_o = ex_target_i.
  - pred_taken=1, ex_taken_i=1, pred_target != ex_target_i -> redirect_pc_o = ex_target_i.
- flush_o is asserted for exactly that one cycle; otherwise flush_o = 0 and redirect_pc_o = 0.
- PC+4 is computed modulo 2^XLEN; wrap at 0xFFFFFFFC gives 0x00000000.
- Predictor update: upd_valid_o = res; upd_pc_o = EX.pc; upd_taken_o = ex_taken_i. All are 0 when res = 0. The predictor writes at the same rising edge.
- Counters at posedge:
  - br_cnt += res.
  - mispred_cnt += flush_o.
  - Each saturates at 2^CNT_W-1 and never wraps.
- A non-branch in EX, or an invalid EX slot, never produces flush or update.
- A stalled EX branch resolves only in the cycle stall_i deasserts, so it is counted once.
- flush_i and a would-be mispredict in the same cycle: flush_i wins; no flush_o, no update, no count.
- rst_n asserted mid-operation: slots and counters clear immediately (asynchronous); outputs fall to 0 without waiting for a clock.

Decomposition:
- CORE_PKG gains:
  - the bp_slot_t struct {valid, pc, pred_taken, pred_target};
  - the localparam PC_STEP = 4;
  - the existing bht_state enum, which is reused by the verification model.
- One sub-module, sat_counter (parameter W, inputs clk, rst_n, inc; output count), is instantiated twice for the performance counters.

Test Plan:
- Correct not-taken: IF pc=0x100, pred=0; two cycles later ex_is_branch=1, taken=0 -> flush_o=0, upd_valid_o=1, upd_pc_o=0x100, upd_taken_o=0, br_cnt=1, mispred_cnt=0.
- Direction mispredict: pc=0x200, pred=0, actual taken, target=0x240 -> flush_o=1 for one cycle, redirect_pc_o=0x240, mispred_cnt=1. ID.valid and EX.valid are 0 next cycle.
- Wrong target: pc=0x300, pred=1 with target 0x380, actual taken to 0x3C0 -> flush_o=1, redirect_pc_o=0x3C0. Predicted taken, actually not taken -> redirect_pc_o=0x304.
- Stall: EX holds mispredicting branch pc=0x400 with stall_i=1 for 3 cycles -> no flush/update during the stall. One flush and br_cnt increment of exactly 1 in the cycle stall_i falls.
- Priority: flush_i=1 in the same cycle as a mispredicting EX branch -> flush_o=0, upd_valid_o=0, counters unchanged, both slots invalid next cycle.
- Reset and saturation: with CNT_W=4, drive 20 resolved branches -> br_cnt_o=15. Pulse rst_n low asynchronously mid-cycle -> counters and outputs are 0 before the next clk edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types for the branch predictor / resolve path.
// Slot bundle, PC step and the 2-bit history state encoding.
package core_pkg;

  localparam int CORE_XLEN = 32;
  localparam int PC_STEP   = 4;

  typedef enum logic [1:0] {
    BHT_SNT,
    BHT_WNT,
    BHT_WT,
    BHT_ST
  } bht_state_e;

  typedef struct packed {
    logic                 valid;
    logic [CORE_XLEN-1:0] pc;
    logic                 pred_taken;
    logic [CORE_XLEN-1:0] pred_target;
  } bp_slot_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
// Ports: clk, rst_n (async low), inc (count enable), count.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Carries IF predictions through ID/EX, resolves them at EX,
// drives flush/redirect, predictor training and perf counters.
module branch_resolve_unit
  import core_pkg::*;
#(
  parameter int XLEN  = CORE_XLEN,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid_i,
  input  logic [XLEN-1:0]  if_pc_i,
  input  logic             if_pred_taken_i,
  input  logic [XLEN-1:0]  if_pred_target_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             ex_is_branch_i,
  input  logic             ex_taken_i,
  input  logic [XLEN-1:0]  ex_target_i,
  output logic             flush_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             upd_valid_o,
  output logic [XLEN-1:0]  upd_pc_o,
  output logic             upd_taken_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  bp_slot_t id_q, id_d;
  bp_slot_t ex_q, ex_d;

  logic res;
  logic dir_miss;
  logic tgt_miss;
  logic mispred;
  logic [XLEN-1:0] seq_pc;

  // Stalled or externally killed EX entries never resolve,
  // so a held branch is counted once, when the stall drops.
  assign res = ex_q.valid & ex_is_branch_i
             & ~stall_i & ~flush_i;

  assign dir_miss = ex_q.pred_taken ^ ex_taken_i;
  assign tgt_miss = ex_q.pred_taken & ex_taken_i
                  & (ex_q.pred_target != ex_target_i);
  assign mispred  = res & (dir_miss | tgt_miss);

  assign seq_pc = ex_q.pc + XLEN'(PC_STEP);

  always_comb begin
    redirect_pc_o = '0;
    if (mispred) begin
      redirect_pc_o = ex_taken_i ? ex_target_i : seq_pc;
    end
  end

  assign flush_o     = mispred;
  assign upd_valid_o = res;
  assign upd_pc_o    = res ? ex_q.pc : '0;
  assign upd_taken_o = res & ex_taken_i;

  always_comb begin
    id_d = id_q;
    ex_d = ex_q;
    if (flush_i || mispred) begin
      id_d.valid = 1'b0;
      ex_d.valid = 1'b0;
    end else if (!stall_i) begin
      ex_d             = id_q;
      id_d.valid       = if_valid_i;
      id_d.pc          = if_pc_i;
      id_d.pred_taken  = if_pred_taken_i;
      id_d.pred_target = if_pred_target_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q <= '0;
      ex_q <= '0;
    end else begin
      id_q <= id_d;
      ex_q <= ex_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (res),
    .count (br_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_mis_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mispred),
    .count (mispred_cnt_o)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (CNT_W=4 to reach
// saturation quickly); vector table plus corner sequences.
module tb_branch_resolve_unit;

  localparam int XL = 32;
  localparam int CW = 4;
  localparam int NV = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_valid_i = 1'b0;
  logic [XL-1:0] if_pc_i = '0;
  logic          if_pred_taken_i = 1'b0;
  logic [XL-1:0] if_pred_target_i = '0;
  logic          stall_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          ex_is_branch_i = 1'b0;
  logic          ex_taken_i = 1'b0;
  logic [XL-1:0] ex_target_i = '0;
  logic          flush_o;
  logic [XL-1:0] redirect_pc_o;
  logic          upd_valid_o;
  logic [XL-1:0] upd_pc_o;
  logic          upd_taken_o;
  logic [CW-1:0] br_cnt_o;
  logic [CW-1:0] mispred_cnt_o;

  branch_resolve_unit #(.XLEN(XL), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_valid_i       (if_valid_i),
    .if_pc_i          (if_pc_i),
    .if_pred_taken_i  (if_pred_taken_i),
    .if_pred_target_i (if_pred_target_i),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .ex_is_branch_i   (ex_is_branch_i),
    .ex_taken_i       (ex_taken_i),
    .ex_target_i      (ex_target_i),
    .flush_o          (flush_o),
    .redirect_pc_o    (redirect_pc_o),
    .upd_valid_o      (upd_valid_o),
    .upd_pc_o         (upd_pc_o),
    .upd_taken_o      (upd_taken_o),
    .br_cnt_o         (br_cnt_o),
    .mispred_cnt_o    (mispred_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [XL-1:0] ipc;
    logic          ipt;
    logic [XL-1:0] itg;
    logic          st;
    logic          fl;
    logic          br;
    logic          tk;
    logic [XL-1:0] tg;
    logic          e_fl;
    logic [XL-1:0] e_rd;
    logic          e_uv;
    logic [XL-1:0] e_up;
    logic          e_ut;
  } vec_t;

  vec_t vt [NV];
  int total = 0;
  int bad = 0;
  int m_br = 0;
  int m_mis = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_cnt(input string nm);
    chk({nm, " br_cnt"}, 64'(br_cnt_o), 64'(m_br));
    chk({nm, " mis_cnt"}, 64'(mispred_cnt_o), 64'(m_mis));
  endtask

  task automatic chk_out(input string nm, input logic efl,
                         input logic [XL-1:0] erd,
                         input logic euv,
                         input logic [XL-1:0] eup,
                         input logic eut);
    chk({nm, " flush"}, 64'(flush_o), 64'(efl));
    chk({nm, " redir"}, 64'(redirect_pc_o), 64'(erd));
    chk({nm, " upd_v"}, 64'(upd_valid_o), 64'(euv));
    chk({nm, " upd_pc"}, 64'(upd_pc_o), 64'(eup));
    chk({nm, " upd_t"}, 64'(upd_taken_o), 64'(eut));
  endtask

  task automatic apply(input vec_t v);
    if_valid_i       = v.iv;
    if_pc_i          = v.ipc;
    if_pred_taken_i  = v.ipt;
    if_pred_target_i = v.itg;
    stall_i          = v.st;
    flush_i          = v.fl;
    ex_is_branch_i   = v.br;
    ex_taken_i       = v.tk;
    ex_target_i      = v.tg;
  endtask

  task automatic tick(input logic uv, input logic fl);
    @(posedge clk);
    #1;
    if (uv && m_br < 15) m_br++;
    if (fl && m_mis < 15) m_mis++;
  endtask

  function automatic vec_t mk(input logic iv,
                              input logic [XL-1:0] ipc,
                              input logic ipt,
                              input logic [XL-1:0] itg,
                              input logic st, input logic fl,
                              input logic br, input logic tk,
                              input logic [XL-1:0] tg);
    vec_t v;
    v = '{iv, ipc, ipt, itg, st, fl, br, tk, tg,
          1'b0, '0, 1'b0, '0, 1'b0};
    return v;
  endfunction

  initial begin
    vec_t v;
    vt[0]  = '{1, 32'h100, 0, 0, 0, 0, 0, 0, 0,
               0, 0, 0, 0, 0};
    vt[1]  = '{1, 32'h200, 0, 0, 0, 0, 0, 0, 0,
               0, 0, 0, 0, 0};
    vt[2]  = '{1, 32'h300, 1, 32'h380, 0, 0, 1, 0, 0,
               0, 0, 1, 32'h100, 0};
    vt[3]  = '{0, 0, 0, 0, 0, 0, 1, 1, 32'h240,
               1, 32'h240, 1, 32'h200, 1};
    vt[4]  = '{0, 0, 0, 0, 0, 0, 1, 1, 32'h240,
               0, 0, 0, 0, 0};
    vt[5]  = '{1, 32'h300, 1, 32'h380, 0, 0, 0, 0, 0,
               0, 0, 0, 0, 0};
    vt[6]  = '{1, 32'h500, 1, 32'h580, 0, 0, 0, 0, 0,
               0, 0, 0, 0, 0};
    vt[7]  = '{1, 32'h600, 1, 32'h680, 0, 0, 1, 1, 32'h3C0,
               1, 32'h3C0, 1, 32'h300, 1};
    vt[8]  = '{1, 32'h700, 1, 32'h780, 0, 0, 1, 1, 0,
               0, 0, 0, 0, 0};
    vt[9]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0,
               0, 0, 0, 0, 0};
    vt[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0,
               1, 32'h704, 1, 32'h700, 0};
    vt[11] = '{1, 32'h800, 1, 32'h900, 0, 0, 0, 0, 0,
               0, 0, 0, 0, 0};
    vt[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
               0, 0, 0, 0, 0};
    vt[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 32'h123,
               0, 0, 0, 0, 0};
    vt[14] = '{1, 32'hFFFF_FFFC, 1, 32'h10, 0, 0, 0, 0, 0,
               0, 0, 0, 0, 0};
    vt[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
               0, 0, 0, 0, 0};
    vt[16] = '{0, 0, 0, 0, 0, 0, 1, 0, 0,
               1, 0, 1, 32'hFFFF_FFFC, 0};
    vt[17] = '{1, 32'hA00, 1, 32'hA40, 0, 0, 0, 0, 0,
               0, 0, 0, 0, 0};
    vt[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
               0, 0, 0, 0, 0};
    vt[19] = '{0, 0, 0, 0, 0, 0, 1, 1, 32'hA40,
               0, 0, 1, 32'hA00, 1};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0, 0, 0);
    chk_cnt("reset");
    rst_n = 1'b1;

    // table
    for (int k = 0; k < NV; k++) begin
      apply(vt[k]);
      @(negedge clk);
      chk_out($sformatf("v%0d", k), vt[k].e_fl, vt[k].e_rd,
              vt[k].e_uv, vt[k].e_up, vt[k].e_ut);
      chk_cnt($sformatf("v%0d", k));
      tick(vt[k].e_uv, vt[k].e_fl);
    end
    chk_cnt("table end");

    // stall: mispredicting branch held 3 cycles
    apply(mk(1, 32'h400, 0, 0, 0, 0, 0, 0, 0));
    tick(0, 0);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick(0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(mk(1, 32'h999, 0, 0, 1, 0, 1, 1, 32'h440));
      @(negedge clk);
      chk_out($sformatf("stall%0d", i), 0, 0, 0, 0, 0);
      tick(0, 0);
      chk_cnt($sformatf("stall%0d", i));
    end
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h440));
    @(negedge clk);
    chk_out("unstall", 1, 32'h440, 1, 32'h400, 1);
    tick(1, 1);
    chk_cnt("unstall");
    @(negedge clk);
    chk_out("post-unstall", 0, 0, 0, 0, 0);
    tick(0, 0);

    // flush_i beats a mispredict; both slots cleared
    apply(mk(1, 32'h500, 0, 0, 0, 0, 0, 0, 0));
    tick(0, 0);
    apply(mk(1, 32'h510, 0, 0, 0, 0, 0, 0, 0));
    tick(0, 0);
    apply(mk(0, 0, 0, 0, 0, 1, 1, 1, 32'h540));
    @(negedge clk);
    chk_out("flush_i", 0, 0, 0, 0, 0);
    tick(0, 0);
    chk_cnt("flush_i");
    for (int i = 0; i < 2; i++) begin
      apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h540));
      @(negedge clk);
      chk_out($sformatf("after_flush%0d", i), 0, 0, 0, 0, 0);
      tick(0, 0);
    end
    chk_cnt("after_flush");

    // saturation: 20 correctly predicted not-taken branches
    for (int i = 0; i < 22; i++) begin
      v = mk(1, 32'h1000 + 32'(4 * i), 0, 0, 0, 0, 1, 0, 0);
      apply(v);
      @(negedge clk);
      chk($sformatf("sat%0d upd_v", i), 64'(upd_valid_o),
          64'(i >= 2));
      chk($sformatf("sat%0d flush", i), 64'(flush_o), 64'(0));
      tick(i >= 2, 0);
    end
    chk("sat br_cnt", 64'(br_cnt_o), 64'(15));
    chk_cnt("sat");

    // async reset mid-cycle while a mispredict is showing
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h2000));
    #1;
    chk("pre-rst flush", 64'(flush_o), 64'(1));
    chk("pre-rst redir", 64'(redirect_pc_o), 64'(32'h2000));
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("async rst", 0, 0, 0, 0, 0);
    m_br = 0;
    m_mis = 0;
    chk_cnt("async rst");
    #1;
    rst_n = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick(0, 0);
    chk_cnt("post rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
